// File: rtl/alu_ex_stage.sv
// alu_ex_stage
// Execute stage: applies the 4-bit ALU control code to two operands and emits a
// registered result with zero, overflow and illegal-code flags, plus a pass-through
// destination tag. Valid/ready on both sides. A two-entry output buffer (output
// register + skid register) sustains one op per cycle under backpressure, and
// ready_o comes straight from a register, with no path from ready_i.
//
// Ports:
//   clk_i, rst_i             clock (rising edge), asynchronous active-low reset
//   valid_i, ready_o         upstream handshake
//   ALUCtrl_i, src1_i,
//   src2_i, tag_i            op code, operands A/B, destination tag
//   valid_o, ready_i         downstream handshake
//   result_o, zero_o,
//   overflow_o, illegal_o,
//   tag_o                    current output beat
//   perf_ops_o, perf_stall_o (only with ALU_EX_PERF_EN) saturating beat-delivered
//                            and upstream-stall counters
//
// Optional build macro: ALU_EX_PERF_EN adds the two performance counters.
module alu_ex_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              illegal_o,
`ifdef ALU_EX_PERF_EN
    output logic [15:0]       perf_ops_o,
    output logic [15:0]       perf_stall_o,
`endif
    output logic [TAG_W-1:0]  tag_o
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              illegal;
        logic              ovf;
        logic              zero;
        logic [DATA_W-1:0] result;
    } beat_t;

    typedef enum logic {EMPTY_SKID, FULL_SKID} skid_state_t;

    // Computes one ALU beat (tag left zero). slt uses sign XOR overflow of A-B,
    // which stays correct when the subtraction overflows.
    function automatic beat_t alu_calc(input logic [3:0] ctrl,
                                       input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        beat_t r;
        logic signed [DATA_W-1:0] sum;
        logic signed [DATA_W-1:0] diff;
        logic ovf_add;
        logic ovf_sub;
        sum     = a + b;
        diff    = a - b;
        ovf_add = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        ovf_sub = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
        r = '0;
        case (ctrl)
            4'b0000: r.result = a & b;
            4'b0001: r.result = a | b;
            4'b0010: begin r.result = sum;  r.ovf = ovf_add; end
            4'b0110: begin r.result = diff; r.ovf = ovf_sub; end
            4'b0111: r.result = {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ ovf_sub};
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.result == '0);
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    skid_state_t state_q, state_d;
    beat_t       beat_p0, out_p1, skid_p2;
    logic        vld_p1, vld_p1_d;
    logic        accept, ld_out_new, ld_skid, mv_skid;

    // ---- p0: combinational ALU on the incoming op ----
    always_comb begin
        beat_p0     = alu_calc(ALUCtrl_i, src1_i, src2_i);
        beat_p0.tag = tag_i;
    end

    assign ready_o = (state_q == EMPTY_SKID);
    assign accept  = valid_i && ready_o;

    always_comb begin
        state_d    = state_q;
        vld_p1_d   = vld_p1;
        ld_out_new = 1'b0;
        ld_skid    = 1'b0;
        mv_skid    = 1'b0;
        case (state_q)
            EMPTY_SKID: begin
                if (accept) begin
                    if (!vld_p1 || ready_i) begin
                        ld_out_new = 1'b1;
                        vld_p1_d   = 1'b1;
                    end else begin
                        ld_skid = 1'b1;
                        state_d = FULL_SKID;
                    end
                end else if (ready_i) begin
                    vld_p1_d = 1'b0;
                end
            end
            FULL_SKID: begin
                // Output register is necessarily full here; refill it from skid.
                if (ready_i) begin
                    mv_skid = 1'b1;
                    state_d = EMPTY_SKID;
                end
            end
            default: state_d = EMPTY_SKID;
        endcase
    end

    // ---- p1 (output register) / p2 (skid register) ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY_SKID;
            vld_p1  <= 1'b0;
            out_p1  <= '0;
            skid_p2 <= '0;
        end else begin
            state_q <= state_d;
            vld_p1  <= vld_p1_d;
            if (ld_out_new)
                out_p1 <= beat_p0;
            else if (mv_skid)
                out_p1 <= skid_p2;
            if (ld_skid)
                skid_p2 <= beat_p0;
        end
    end

    assign valid_o    = vld_p1;
    assign result_o   = out_p1.result;
    assign zero_o     = out_p1.zero;
    assign overflow_o = out_p1.ovf;
    assign illegal_o  = out_p1.illegal;
    assign tag_o      = out_p1.tag;

`ifdef ALU_EX_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_ops_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (vld_p1 && ready_i)
                perf_ops_o <= sat_inc(perf_ops_o);
            if (valid_i && !ready_o)
                perf_stall_o <= sat_inc(perf_stall_o);
        end
    end
`endif

endmodule
